// File: rtl/conway_pkg.sv
// Shared Game-of-Life constants and scan FSM state type.
package conway_pkg;
  localparam int BOARD_WIDTH  = 8;
  localparam int BOARD_HEIGHT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } scan_state_t;
endpackage

// File: rtl/board_stream_out_scan_counter.sv
// Row-major row/column scan counter with clear and advance.
// Wraps at WIDTH-1 / HEIGHT-1, safe for non-power-of-two sizes.
import conway_pkg::*;

module scan_counter #(
  parameter int WIDTH  = BOARD_WIDTH,
  parameter int HEIGHT = BOARD_HEIGHT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic                      last
);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(WIDTH - 1));
  assign row_end = (row_q == RW'(HEIGHT - 1));

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Next count: clear wins, otherwise step column then row
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = col_end & row_end;
endmodule

// File: rtl/board_stream_out.sv
// Snapshots the board on START and streams it one cell per beat.
// POPULATION_COUNT_EN adds a live-cell count of the last scan.
import conway_pkg::*;

module board_stream_out #(
  parameter int WIDTH  = BOARD_WIDTH,
  parameter int HEIGHT = BOARD_HEIGHT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH*HEIGHT-1:0]   BOARD,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      CELL_VALID,
  input  logic                      CELL_READY,
  output logic                      CELL_DATA,
  output logic [$clog2(HEIGHT)-1:0] CELL_ROW,
  output logic [$clog2(WIDTH)-1:0]  CELL_COL,
  output logic                      CELL_LAST,
`ifdef POPULATION_COUNT_EN
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] POPULATION,
`endif
  output logic                      DONE
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);

  scan_state_t state_q, state_d;
  logic [N-1:0] snap_q, snap_d;
  logic         done_q, done_d;
  logic         clear;
  logic         hs;
  logic         last;
  logic [$clog2(HEIGHT)-1:0] row;
  logic [$clog2(WIDTH)-1:0]  col;
  logic [IW-1:0] idx;

  assign hs  = CELL_VALID & CELL_READY;
  assign idx = IW'(row) * IW'(WIDTH) + IW'(col);

  scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cnt (
    .clk     (CLK),
    .rst     (RST),
    .clear   (clear),
    .advance (hs),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // State, snapshot and done-pulse registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  // Next state: capture on START in IDLE, leave SEND on last handshake
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SEND;
          snap_d  = BOARD;
          clear   = 1'b1;
        end
      end
      SEND: begin
        if (hs && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs are forced to zero outside SEND
  always_comb begin
    BUSY       = 1'b0;
    CELL_VALID = 1'b0;
    CELL_DATA  = 1'b0;
    CELL_ROW   = '0;
    CELL_COL   = '0;
    CELL_LAST  = 1'b0;
    if (state_q == SEND) begin
      BUSY       = 1'b1;
      CELL_VALID = 1'b1;
      CELL_DATA  = snap_q[idx];
      CELL_ROW   = row;
      CELL_COL   = col;
      CELL_LAST  = last;
    end
  end

  assign DONE = done_q;

`ifdef POPULATION_COUNT_EN
  localparam int PW = $clog2(N + 1);

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] pop_q, pop_d;

  // Live-cell accumulator and published count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
      pop_q <= '0;
    end else begin
      acc_q <= acc_d;
      pop_q <= pop_d;
    end
  end

  // Clear on capture, add per beat, publish on the final beat
  always_comb begin
    acc_d = acc_q;
    pop_d = pop_q;
    if (clear) begin
      acc_d = '0;
    end else if (hs) begin
      acc_d = acc_q + PW'(CELL_DATA);
      if (last) begin
        pop_d = acc_q + PW'(CELL_DATA);
      end
    end
  end

  assign POPULATION = pop_q;
`endif
endmodule

// File: tb/tb_board_stream_out.sv
// Directed bench for board_stream_out on a 4x4 and a 3x5 board.
// POPULATION checks compile in with POPULATION_COUNT_EN.
module tb_board_stream_out;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        a_rst;
  logic [15:0] a_board;
  logic        a_start;
  logic        a_ready;
  logic        a_busy;
  logic        a_valid;
  logic        a_data;
  logic [1:0]  a_row;
  logic [1:0]  a_col;
  logic        a_last;
  logic        a_done;
`ifdef POPULATION_COUNT_EN
  logic [4:0]  a_pop;
`endif

  logic        b_rst;
  logic [14:0] b_board;
  logic        b_start;
  logic        b_ready;
  logic        b_busy;
  logic        b_valid;
  logic        b_data;
  logic [2:0]  b_row;
  logic [1:0]  b_col;
  logic        b_last;
  logic        b_done;
`ifdef POPULATION_COUNT_EN
  logic [3:0]  b_pop;
`endif

  board_stream_out #(.WIDTH(4), .HEIGHT(4)) u_a (
    .CLK        (clk),
    .RST        (a_rst),
    .BOARD      (a_board),
    .START      (a_start),
    .BUSY       (a_busy),
    .CELL_VALID (a_valid),
    .CELL_READY (a_ready),
    .CELL_DATA  (a_data),
    .CELL_ROW   (a_row),
    .CELL_COL   (a_col),
    .CELL_LAST  (a_last),
`ifdef POPULATION_COUNT_EN
    .POPULATION (a_pop),
`endif
    .DONE       (a_done)
  );

  board_stream_out #(.WIDTH(3), .HEIGHT(5)) u_b (
    .CLK        (clk),
    .RST        (b_rst),
    .BOARD      (b_board),
    .START      (b_start),
    .BUSY       (b_busy),
    .CELL_VALID (b_valid),
    .CELL_READY (b_ready),
    .CELL_DATA  (b_data),
    .CELL_ROW   (b_row),
    .CELL_COL   (b_col),
    .CELL_LAST  (b_last),
`ifdef POPULATION_COUNT_EN
    .POPULATION (b_pop),
`endif
    .DONE       (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_idle_chk(input string tag);
    chk({tag, " valid"}, 32'(a_valid), 0);
    chk({tag, " busy"}, 32'(a_busy), 0);
    chk({tag, " data"}, 32'(a_data), 0);
    chk({tag, " row"}, 32'(a_row), 0);
    chk({tag, " col"}, 32'(a_col), 0);
    chk({tag, " last"}, 32'(a_last), 0);
  endtask

  // One full 4x4 scan; options: stall pattern, board mutation, START pokes
  task automatic scan_a(input logic [15:0] brd, input bit stall,
                        input bit mutate, input bit restart);
    int k;
    int cyc;
    logic [15:0] snap;
    logic [3:0] pat;
    pat = 4'b1001;
    snap = brd;
    a_board = brd;
    a_start = 1'b1;
    a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      a_start = 1'b0;
      a_ready = stall ? pat[cyc%4] : 1'b1;
      if (mutate) a_board = 16'hFFFF;
      if (restart && (k == 5 || k == 15)) a_start = 1'b1;
      chk("a valid", 32'(a_valid), 1);
      chk("a busy", 32'(a_busy), 1);
      chk("a data", 32'(a_data), 32'(snap[k]));
      chk("a row", 32'(a_row), 32'(k / 4));
      chk("a col", 32'(a_col), 32'(k % 4));
      chk("a last", 32'(a_last), 32'(k == 15));
      chk("a done mid", 32'(a_done), 0);
      if (a_valid && a_ready) k++;
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    chk("a beats", 32'(k), 16);
    if (!stall) chk("a cycles", 32'(cyc), 16);
    chk("a done", 32'(a_done), 1);
    a_idle_chk("a after");
`ifdef POPULATION_COUNT_EN
    chk("a pop", 32'(a_pop), 32'($countones(snap)));
`endif
    @(negedge clk);
    chk("a done drop", 32'(a_done), 0);
    for (int i = 0; i < 3; i++) begin
      a_idle_chk("a idle");
      @(negedge clk);
    end
  endtask

  initial begin
    int k;
    a_rst = 1'b1; a_board = '0; a_start = 1'b0; a_ready = 1'b0;
    b_rst = 1'b1; b_board = '0; b_start = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    a_idle_chk("rst");
    chk("rst done", 32'(a_done), 0);
`ifdef POPULATION_COUNT_EN
    chk("rst pop", 32'(a_pop), 0);
`endif
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    a_idle_chk("idle");

    scan_a(16'h8001, 1'b0, 1'b0, 1'b0);
    scan_a(16'hA5C3, 1'b1, 1'b0, 1'b0);
    scan_a(16'h1234, 1'b0, 1'b1, 1'b0);
    scan_a(16'h8001, 1'b0, 1'b0, 1'b1);

    // Reset while beat 5 is presented
    a_board = 16'hFFFF;
    a_start = 1'b1;
    a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (k < 4) begin
      if (a_valid) k++;
      @(negedge clk);
    end
    chk("pre-rst col", 32'(a_col), 0);
    chk("pre-rst row", 32'(a_row), 1);
    a_rst = 1'b1;
    #1;
    a_idle_chk("async rst");
    chk("async rst done", 32'(a_done), 0);
`ifdef POPULATION_COUNT_EN
    chk("async rst pop", 32'(a_pop), 0);
`endif
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-rst done", 32'(a_done), 0);
      a_idle_chk("post-rst");
    end
    scan_a(16'h0F0F, 1'b0, 1'b0, 1'b0);

    // 3x5 all-ones board
    b_board = 15'h7FFF;
    b_start = 1'b1;
    b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 15; cyc++) begin
      chk("b valid", 32'(b_valid), 1);
      chk("b data", 32'(b_data), 1);
      chk("b row", 32'(b_row), 32'(k / 3));
      chk("b col", 32'(b_col), 32'(k % 3));
      chk("b last", 32'(b_last), 32'(k == 14));
      if (b_valid && b_ready) k++;
      @(negedge clk);
    end
    chk("b beats", 32'(k), 15);
    chk("b done", 32'(b_done), 1);
    chk("b busy", 32'(b_busy), 0);
    chk("b valid end", 32'(b_valid), 0);
`ifdef POPULATION_COUNT_EN
    chk("b pop", 32'(b_pop), 15);
`endif
    @(negedge clk);
    chk("b done drop", 32'(b_done), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/board_stream_out.md
# board_stream_out

Serializes a snapshot of the Game-of-Life board into a one-cell-per-beat stream with a valid/ready handshake, in row-major order. It is the read-out end of the board: the per-cell next-state logic writes the board register in parallel, and this block carries it out to a display, UART bridge or testbench. On START it captures the whole parallel board, so the generation logic may keep stepping while the scan runs. It emits row/column tags, a last flag and a completion pulse.

## Interface
- WIDTH, 8, board columns (≥2)
- HEIGHT, 8, board rows (≥2)
- CLK  in  1  sole clock, rising edge
- RST  in  1  asynchronous, active-high reset
- BOARD  in  WIDTH*HEIGHT  live board; bit r*WIDTH+c is the cell at row r, column c; row 0 is north, column 0 is west
- START  in  1  request a scan; sampled only in IDLE
- BUSY  out  1  high from the cycle after an accepted START through the final handshake
- CELL_VALID  out  1  stream beat valid
- CELL_READY  in  1  sink accepts the beat
- CELL_DATA  out  1  cell alive (1) / dead (0)
- CELL_ROW  out  $clog2(HEIGHT)  row of the current beat
- CELL_COL  out  $clog2(WIDTH)  column of the current beat
- CELL_LAST  out  1  high on the beat for row HEIGHT-1, column WIDTH-1
- DONE  out  1  one-cycle pulse after the final handshake
- POPULATION  out  $clog2(WIDTH*HEIGHT+1)  live-cell count of the last completed scan; present only when POPULATION_COUNT_EN is defined

## Operation
- FSM has two states: IDLE and SEND.
- IDLE with START=1:
  - copy BOARD into the snapshot register
  - clear row and column to 0
  - go to SEND
- IDLE with START=0: stay in IDLE.
- SEND:
  - CELL_VALID=1
  - CELL_DATA = snapshot[row*WIDTH+col]
  - CELL_ROW and CELL_COL show the counters
- Handshake occurs on an edge where CELL_VALID and CELL_READY are both high.
  - After a handshake, col increments.
  - At col=WIDTH-1, col wraps to 0 and row increments.
- Handshake with CELL_LAST=1: go to IDLE and assert DONE for the next cycle.
- Back-pressure:
  - While CELL_VALID=1 and CELL_READY=0, CELL_DATA, CELL_ROW, CELL_COL and CELL_LAST hold stable.
  - CELL_VALID never deasserts before its handshake.
- START is ignored while in SEND; there is no queueing.
- START in the same cycle as the final handshake is ignored. The sink must re-assert START once the block is in IDLE.
- Changes on BOARD during SEND do not affect the stream, because the snapshot is frozen.
- Outside SEND:
  - CELL_VALID=0
  - CELL_DATA, CELL_ROW, CELL_COL and CELL_LAST are 0
- The counters never exceed HEIGHT-1 or WIDTH-1, including non-power-of-two sizes.

## Timing
- START sampled high at edge t: CELL_VALID and BUSY are high in cycle t+1. Latency is one cycle.
- Throughput is one cell per cycle while CELL_READY is held high.
- A full scan with no stalls is WIDTH*HEIGHT cycles in SEND.
- DONE is high exactly one cycle, the cycle after the last handshake. BUSY=0 in that cycle.
- Reset values of all outputs are 0: CELL_VALID, CELL_DATA, CELL_ROW, CELL_COL, CELL_LAST, BUSY, DONE and POPULATION. The FSM resets to IDLE and the snapshot to 0.
- Reset asserted mid-scan:
  - outputs clear immediately (asynchronous)
  - no DONE pulse
  - the scan is abandoned, with no resume
- Reset is deasserted synchronously to CLK by the top level.

## Configuration
- POPULATION_COUNT_EN defined:
  - The POPULATION port exists.
  - An internal accumulator clears on an accepted START.
  - It adds CELL_DATA on each handshake.
  - It is copied to POPULATION on the final handshake, so POPULATION is valid when DONE is high.
  - POPULATION holds until the next scan completes.
- POPULATION_COUNT_EN not defined: the port, accumulator and adder are absent. All other behaviour is identical.

## Structure
- Shared package conway_pkg holds:
  - BOARD_WIDTH and BOARD_HEIGHT default constants, used as the parameter defaults here
  - the scan_state_t enum {IDLE, SEND}
- One sub-module, scan_counter:
  - row/column counter
  - parameterized by WIDTH and HEIGHT
  - inputs: clear, advance
  - outputs: row, col, last
  - reused for future board loaders

## Test plan
- 4x4 board, BOARD=16'h8001, START pulse, CELL_READY=1:
  - 16 beats
  - CELL_DATA=1 only at (0,0) and (3,3)
  - CELL_LAST only on the 16th beat
  - DONE one cycle later
  - POPULATION=2
- CELL_READY toggles 1,0,0,1 repeatedly: data and tags are stable during stalls, no beats are lost or duplicated, and 16 handshakes occur.
- BOARD changed to all-ones during the scan: the stream still matches the original snapshot.
- START re-pulsed mid-scan and coincident with the final handshake: no restart, and no new scan begins until START is asserted again in IDLE.
- RST asserted on beat 5: all outputs are 0 at once, no DONE, and a fresh START restarts at (0,0).
- 3x5 board, all-ones: the column wraps at 2 and the row reaches 4, with 15 beats and POPULATION=15.
